// File: rtl/change_dispense_ctrl_if.sv
// Bus between the vending FSM (master) and the coin-return sequencer (slave).
// Request rule: i_start is taken only while the sequencer sits in IDLE (o_busy and
// o_fault both low); a pulse at any other time is dropped, never queued.
interface change_dispense_ctrl_if;
    logic       i_start;
    logic [4:0] i_change;
    logic [2:0] i_empty;
    logic       i_coin_ok;
    logic       i_clear;
    logic [2:0] o_eject;
    logic       o_busy;
    logic       o_done;
    logic       o_fault;
    logic [4:0] o_remain;
    logic [4:0] o_dispensed;
    logic [2:0] dbg_state;

    modport master (
        output i_start, i_change, i_empty, i_coin_ok, i_clear,
        input  o_eject, o_busy, o_done, o_fault, o_remain, o_dispensed, dbg_state
    );

    modport slave (
        input  i_start, i_change, i_empty, i_coin_ok, i_clear,
        output o_eject, o_busy, o_done, o_fault, o_remain, o_dispensed, dbg_state
    );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: pays out change largest coin first (10, 5, 1 jiao units),
// waits for each drop confirmation and falls back to smaller coins on empty/jammed hoppers.
module change_dispense_ctrl #(
    parameter int PULSE_W     = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    change_dispense_ctrl_if.slave bus
);

    localparam int CMAX = (PULSE_W > ACK_TIMEOUT) ? PULSE_W : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    remain_q, remain_d;
    logic [4:0]    disp_q, disp_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    jam_q, jam_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    sel_val;

    // Face value of the latched one-hot coin selection.
    always_comb begin
        sel_val = 5'd0;
        case (sel_q)
            3'b100:  sel_val = 5'd10;
            3'b010:  sel_val = 5'd5;
            3'b001:  sel_val = 5'd1;
            default: sel_val = 5'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            remain_q <= 5'd0;
            disp_q   <= 5'd0;
            sel_q    <= 3'b000;
            jam_q    <= 3'b000;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            disp_q   <= disp_d;
            sel_q    <= sel_d;
            jam_q    <= jam_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        disp_d   = disp_q;
        sel_d    = sel_q;
        jam_d    = jam_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    remain_d = bus.i_change;
                    disp_d   = 5'd0;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                cnt_d = '0;
                if (remain_q == 5'd0) begin
                    state_d = DONE;
                end else if (remain_q >= 5'd10 && !bus.i_empty[2] && !jam_q[2]) begin
                    sel_d   = 3'b100;
                    state_d = EJECT;
                end else if (remain_q >= 5'd5 && !bus.i_empty[1] && !jam_q[1]) begin
                    sel_d   = 3'b010;
                    state_d = EJECT;
                end else if (!bus.i_empty[0] && !jam_q[0]) begin
                    sel_d   = 3'b001;
                    state_d = EJECT;
                end else begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_ACK: begin
                // An ack landing on the timeout cycle still wins over the jam.
                if (bus.i_coin_ok) begin
                    remain_d = remain_q - sel_val;
                    disp_d   = disp_q + sel_val;
                    state_d  = SELECT;
                end else if (cnt_q == ACK_LAST) begin
                    jam_d   = jam_q | sel_q;
                    state_d = SELECT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (bus.i_clear) begin
                    jam_d   = 3'b000;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign bus.o_eject     = (state_q == EJECT) ? sel_q : 3'b000;
    assign bus.o_busy      = (state_q != IDLE) && (state_q != FAULT);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_fault     = (state_q == FAULT);
    assign bus.o_remain    = remain_q;
    assign bus.o_dispensed = disp_q;
    assign bus.dbg_state   = state_q;

endmodule
